// File: rtl/lite_mailbox_pkg.sv
// Shared constants for the Xillybus Lite mailbox:
// register word offsets, ID value, IRQ bits and STATUS fields.
package lite_mailbox_pkg;

  localparam logic [2:0] REG_ID         = 3'd0;
  localparam logic [2:0] REG_SCRATCH    = 3'd1;
  localparam logic [2:0] REG_TX_DATA    = 3'd2;
  localparam logic [2:0] REG_RX_DATA    = 3'd3;
  localparam logic [2:0] REG_STATUS     = 3'd4;
  localparam logic [2:0] REG_IRQ_STATUS = 3'd5;
  localparam logic [2:0] REG_IRQ_ENABLE = 3'd6;

  localparam logic [31:0] MBOX_ID = 32'h4D424F58;

  localparam int IRQ_RX_AVAIL   = 0;
  localparam int IRQ_TX_DRAINED = 1;
  localparam int IRQ_OVERFLOW   = 2;
  localparam int IRQ_UNDERFLOW  = 3;

  localparam int ST_TX_COUNT = 0;
  localparam int ST_RX_COUNT = 8;
  localparam int ST_TX_FULL  = 16;
  localparam int ST_RX_EMPTY = 17;

endpackage

// File: rtl/mbox_fifo.sv
// First-word-fall-through FIFO; data_out shows the head
// combinationally and reads as zero while empty.
module mbox_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  pop,
  output logic [WIDTH-1:0]      data_out,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT =
    {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2:0]   cnt;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign data_out = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      cnt <= cnt
           + {{DEPTH_LOG2{1'b0}}, do_push}
           - {{DEPTH_LOG2{1'b0}}, do_pop};
    end
  end

  // Storage is not reset; empty masks stale words.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= data_in;
  end

endmodule

// File: rtl/lite_mailbox.sv
// Xillybus Lite register mailbox: ID, scratch, TX/RX FIFOs,
// status and a level interrupt with sticky W1C flags.
module lite_mailbox
  import lite_mailbox_pkg::*;
#(
  parameter int          DEPTH_LOG2    = 4,
  parameter logic [31:0] SCRATCH_RESET = 32'h0
) (
  input  logic        bus_clk,
  input  logic        bus_rst,
  input  logic        user_wren,
  input  logic [3:0]  user_wstrb,
  input  logic        user_rden,
  input  logic [31:0] user_addr,
  input  logic [31:0] user_wr_data,
  output logic [31:0] user_rd_data,
  output logic        user_irq,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam logic [DEPTH_LOG2:0] CNT_ONE =
    {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [2:0]          idx;
  logic                tx_full, tx_empty;
  logic                rx_full, rx_empty;
  logic [DEPTH_LOG2:0] tx_count, rx_count;
  logic [31:0]         rx_head;
  logic                wr_tx, tx_push, tx_pop;
  logic                rd_rx, rx_pop, rx_push;
  logic                ovf_set, unf_set, drain_set;
  logic [3:1]          w1c;
  logic [3:1]          sticky;
  logic [3:0]          irq_en;
  logic [3:0]          irq_status;
  logic [31:0]         scratch;
  logic [31:0]         status;
  logic [31:0]         rd_mux;

  assign idx = user_addr[4:2];

  assign wr_tx   = user_wren && idx == REG_TX_DATA
                && user_wstrb == 4'hF;
  assign tx_push = wr_tx & ~tx_full;
  assign ovf_set = wr_tx & tx_full;
  assign tx_valid = ~tx_empty;
  assign tx_pop  = tx_valid & tx_ready;

  assign rd_rx   = user_rden && idx == REG_RX_DATA;
  assign rx_pop  = rd_rx & ~rx_empty;
  assign unf_set = rd_rx & rx_empty;
  assign rx_ready = ~rx_full;
  assign rx_push = rx_valid & rx_ready;

  // Last word leaving with nothing arriving behind it.
  assign drain_set = tx_pop && tx_count == CNT_ONE && !tx_push;

  assign w1c = (user_wren && idx == REG_IRQ_STATUS
             && user_wstrb[0]) ? user_wr_data[3:1] : 3'b0;

  mbox_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(32)) u_tx (
    .clk      (bus_clk),
    .rst      (bus_rst),
    .push     (tx_push),
    .data_in  (user_wr_data),
    .pop      (tx_pop),
    .data_out (tx_data),
    .full     (tx_full),
    .empty    (tx_empty),
    .count    (tx_count)
  );

  mbox_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(32)) u_rx (
    .clk      (bus_clk),
    .rst      (bus_rst),
    .push     (rx_push),
    .data_in  (rx_data),
    .pop      (rx_pop),
    .data_out (rx_head),
    .full     (rx_full),
    .empty    (rx_empty),
    .count    (rx_count)
  );

  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      scratch <= SCRATCH_RESET;
    end else if (user_wren && idx == REG_SCRATCH) begin
      for (int b = 0; b < 4; b++) begin
        if (user_wstrb[b])
          scratch[8*b +: 8] <= user_wr_data[8*b +: 8];
      end
    end
  end

  // Sets are OR-ed after the clear so a same-cycle set wins.
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      sticky <= '0;
      irq_en <= '0;
    end else begin
      sticky <= (sticky & ~w1c)
              | {unf_set, ovf_set, drain_set};
      if (user_wren && idx == REG_IRQ_ENABLE && user_wstrb[0])
        irq_en <= user_wr_data[3:0];
    end
  end

  always_comb begin
    irq_status = '0;
    irq_status[IRQ_RX_AVAIL]   = ~rx_empty;
    irq_status[IRQ_TX_DRAINED] = sticky[IRQ_TX_DRAINED];
    irq_status[IRQ_OVERFLOW]   = sticky[IRQ_OVERFLOW];
    irq_status[IRQ_UNDERFLOW]  = sticky[IRQ_UNDERFLOW];
  end

  always_comb begin
    status = '0;
    status[ST_TX_COUNT +: 8] = 8'(tx_count);
    status[ST_RX_COUNT +: 8] = 8'(rx_count);
    status[ST_TX_FULL]       = tx_full;
    status[ST_RX_EMPTY]      = rx_empty;
  end

  always_comb begin
    rd_mux = '0;
    case (idx)
      REG_ID:         rd_mux = MBOX_ID;
      REG_SCRATCH:    rd_mux = scratch;
      REG_RX_DATA:    rd_mux = rx_head;
      REG_STATUS:     rd_mux = status;
      REG_IRQ_STATUS: rd_mux = {28'b0, irq_status};
      REG_IRQ_ENABLE: rd_mux = {28'b0, irq_en};
      default:        rd_mux = '0;
    endcase
  end

  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      user_rd_data <= '0;
      user_irq     <= 1'b0;
    end else begin
      if (user_rden) user_rd_data <= rd_mux;
      user_irq <= |(irq_status & irq_en);
    end
  end

endmodule
